// File: rtl/atconv_gen2.sv
// Dilated 3x3 convolution with ReLU/saturation into layer0, then optional
// 2x2 max pooling with round-up-to-integer into layer1.
module atconv_gen2 #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = 13,
  parameter int FRAC   = 4,
  parameter int AW     = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ready,
  input  logic [1:0]                 dil,
  input  logic                       pool_en,
  input  logic [9*DATA_W-1:0]        kernel,
  input  logic signed [DATA_W-1:0]   bias,
  output logic                       busy,
  output logic                       done,
  output logic [AW-1:0]              iaddr,
  input  logic signed [DATA_W-1:0]   idata,
  output logic                       cwr,
  output logic                       csel,
  output logic [AW-1:0]              caddr_wr,
  output logic [DATA_W-1:0]          cdata_wr,
  output logic                       crd,
  output logic [AW-1:0]              caddr_rd,
  input  logic signed [DATA_W-1:0]   cdata_rd
);

  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int PXW  = XW - 1;
  localparam int PYW  = YW - 1;
  localparam int ACCW = 2*DATA_W + 4;
  localparam int CW   = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2**(DATA_W-1)) - 1);
  localparam logic signed [DATA_W:0] INT_MAX =
    {2'b00, {(DATA_W-1-FRAC){1'b1}}, {FRAC{1'b0}}};

  typedef enum logic [1:0] {IDLE, CONV, POOL, PWR} state_t;

  state_t                     state;
  logic [XW-1:0]              x;
  logic [YW-1:0]              y;
  logic [1:0]                 tr, tc;
  logic [PXW-1:0]             px;
  logic [PYW-1:0]             py;
  logic [1:0]                 ps;
  logic [2:0]                 d;
  logic                       pool_r;
  logic signed [DATA_W-1:0]   coef [9];
  logic signed [DATA_W-1:0]   bias_r;
  logic signed [ACCW-1:0]     acc;
  logic signed [DATA_W-1:0]   mx;

  logic [3:0]                 k;
  logic signed [CW-1:0]       ds, dx, dy, sx, sy;
  logic [XW-1:0]              cx;
  logic [YW-1:0]              cy;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACCW-1:0]     sum, res;
  logic [DATA_W-1:0]          act;
  logic signed [DATA_W:0]     mfl, mup;
  logic [DATA_W-1:0]          rounded;
  logic                       last_x, last_y, last_px, last_py;

  assign k       = {1'b0, tr, 1'b0} + {2'b00, tr} + {2'b00, tc};
  assign last_x  = (x == XW'(IMG_W-1));
  assign last_y  = (y == YW'(IMG_H-1));
  assign last_px = (px == PXW'(IMG_W/2-1));
  assign last_py = (py == PYW'(IMG_H/2-1));

  // Tap coordinate with replicate padding, then the MAC for the current tap.
  always_comb begin
    ds = signed'(CW'(d));
    dx = (tc == 2'd0) ? -ds : ((tc == 2'd2) ? ds : '0);
    dy = (tr == 2'd0) ? -ds : ((tr == 2'd2) ? ds : '0);
    sx = signed'(CW'(x)) + dx;
    sy = signed'(CW'(y)) + dy;
    cx = (sx < 0) ? '0 : ((sx > CW'(IMG_W-1)) ? XW'(IMG_W-1) : XW'(sx));
    cy = (sy < 0) ? '0 : ((sy > CW'(IMG_H-1)) ? YW'(IMG_H-1) : YW'(sy));
    prod = (2*DATA_W)'(idata) * (2*DATA_W)'(coef[k]);
    sum  = ((tr == 2'd0 && tc == 2'd0) ? '0 : acc) + ACCW'(prod);
    res  = (sum >>> FRAC) + ACCW'(bias_r);
    act  = (res < 0) ? '0 : ((res > SAT_MAX) ? DATA_W'(SAT_MAX) : DATA_W'(res));
    mfl  = {mx[DATA_W-1], mx[DATA_W-1:FRAC], {FRAC{1'b0}}};
    mup  = mfl + ((|mx[FRAC-1:0]) ? (DATA_W+1)'(2**FRAC) : '0);
    rounded = (mup > INT_MAX) ? DATA_W'(INT_MAX) : DATA_W'(mup);
  end

  always_comb begin
    busy     = (state != IDLE);
    iaddr    = '0;
    cwr      = 1'b0;
    csel     = 1'b0;
    caddr_wr = '0;
    cdata_wr = '0;
    crd      = 1'b0;
    caddr_rd = '0;
    case (state)
      CONV: begin
        iaddr    = AW'({cy, cx});
        caddr_wr = AW'({y, x});
        cdata_wr = act;
        cwr      = (tr == 2'd2) && (tc == 2'd2);
      end
      POOL: begin
        crd      = 1'b1;
        caddr_rd = AW'({py, ps[1], px, ps[0]});
        caddr_wr = AW'({py, px});
        cdata_wr = rounded;
      end
      PWR: begin
        cwr      = 1'b1;
        csel     = 1'b1;
        caddr_wr = AW'({py, px});
        cdata_wr = rounded;
      end
      default: ;
    endcase
  end

  // Ready is ignored during the done cycle so a new job starts one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      x      <= '0;
      y      <= '0;
      tr     <= '0;
      tc     <= '0;
      px     <= '0;
      py     <= '0;
      ps     <= '0;
      d      <= '0;
      pool_r <= 1'b0;
      bias_r <= '0;
      acc    <= '0;
      mx     <= '0;
      for (int i = 0; i < 9; i++) coef[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ready && !done) begin
            state  <= CONV;
            d      <= 3'(dil) + 3'd1;
            pool_r <= pool_en;
            bias_r <= bias;
            for (int i = 0; i < 9; i++) coef[i] <= kernel[i*DATA_W +: DATA_W];
            x  <= '0;
            y  <= '0;
            tr <= '0;
            tc <= '0;
          end
        end
        CONV: begin
          acc <= sum;
          if (tc != 2'd2) begin
            tc <= tc + 2'd1;
          end else begin
            tc <= '0;
            if (tr != 2'd2) begin
              tr <= tr + 2'd1;
            end else begin
              tr <= '0;
              x  <= x + 1'b1;
              if (last_x) begin
                x <= '0;
                y <= y + 1'b1;
                if (last_y) begin
                  y <= '0;
                  if (pool_r) begin
                    state <= POOL;
                    px    <= '0;
                    py    <= '0;
                    ps    <= '0;
                  end else begin
                    state <= IDLE;
                    done  <= 1'b1;
                  end
                end
              end
            end
          end
        end
        POOL: begin
          if (ps == 2'd0 || cdata_rd > mx) mx <= cdata_rd;
          ps <= ps + 2'd1;
          if (ps == 2'd3) state <= PWR;
        end
        PWR: begin
          state <= POOL;
          px    <= px + 1'b1;
          if (last_px) begin
            px <= '0;
            py <= py + 1'b1;
            if (last_py) begin
              py    <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atconv_gen2.sv
// Randomized and directed bench for atconv_gen2 on an 8x8 image, checked
// cycle by cycle against a behavioural model of conv + pooling.
module tb_atconv_gen2;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 13;
  localparam int AW = 6;
  localparam int CONV_LEN = 9*W*H;
  localparam int POOL_LEN = 5*(W/2)*(H/2);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ready = 1'b0;
  logic [1:0]           dil = '0;
  logic                 pool_en = 1'b0;
  logic [9*DW-1:0]      kernel = '0;
  logic signed [DW-1:0] bias = '0;
  logic                 busy, done, cwr, csel, crd;
  logic [AW-1:0]        iaddr, caddr_wr, caddr_rd;
  logic signed [DW-1:0] idata, cdata_rd;
  logic [DW-1:0]        cdata_wr;

  int img_v [W*H];
  int l0_mem [W*H];
  int l1_mem [W*H/4];
  int exp_l0 [W*H];
  int exp_l1 [W*H/4];
  int m_k [9];
  int m_bias, m_d, m_pool;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int total_len = 0;
  bit active = 1'b0;

  atconv_gen2 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .FRAC(4), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .dil(dil), .pool_en(pool_en),
    .kernel(kernel), .bias(bias), .busy(busy), .done(done), .iaddr(iaddr),
    .idata(idata), .cwr(cwr), .csel(csel), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  assign idata    = DW'(img_v[iaddr]);
  assign cdata_rd = DW'(l0_mem[caddr_rd]);

  // External layer memories
  always @(posedge clk) begin
    if (cwr) begin
      if (!csel) l0_mem[caddr_wr] <= int'(cdata_wr);
      else       l1_mem[caddr_wr[3:0]] <= int'(cdata_wr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic compute_model();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        longint acc = 0;
        longint res;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            int sx = clampi(x + (c-1)*m_d, W-1);
            int sy = clampi(y + (r-1)*m_d, H-1);
            acc += longint'(img_v[sy*W+sx]) * longint'(m_k[3*r+c]);
          end
        res = (acc >>> 4) + m_bias;
        exp_l0[y*W+x] = (res < 0) ? 0 : ((res > 4095) ? 4095 : int'(res));
      end
    for (int py = 0; py < H/2; py++)
      for (int px = 0; px < W/2; px++) begin
        int m = exp_l0[(2*py)*W + 2*px];
        int up;
        if (exp_l0[(2*py)*W + 2*px+1] > m)   m = exp_l0[(2*py)*W + 2*px+1];
        if (exp_l0[(2*py+1)*W + 2*px] > m)   m = exp_l0[(2*py+1)*W + 2*px];
        if (exp_l0[(2*py+1)*W + 2*px+1] > m) m = exp_l0[(2*py+1)*W + 2*px+1];
        up = m - (m % 16) + (((m % 16) != 0) ? 16 : 0);
        exp_l1[py*(W/2)+px] = (up > 4080) ? 4080 : up;
      end
  endtask

  task automatic check_output(input int c);
    chk("busy", int'(busy), int'(c < total_len));
    chk("done", int'(done), int'(c == total_len));
    if (c < CONV_LEN) begin
      int p = c / 9, t = c % 9;
      int x = p % W, y = p / W, r = t / 3, cc = t % 3;
      chk("iaddr", int'(iaddr),
          clampi(y + (r-1)*m_d, H-1)*W + clampi(x + (cc-1)*m_d, W-1));
      chk("crd", int'(crd), 0);
      chk("cwr", int'(cwr), int'(t == 8));
      if (t == 8) begin
        chk("conv_csel", int'(csel), 0);
        chk("conv_addr", int'(caddr_wr), p);
        chk("conv_data", int'(cdata_wr), exp_l0[p]);
      end
    end else if (c < total_len) begin
      int q = c - CONV_LEN;
      int j = q / 5, s = q % 5;
      int px = j % (W/2), py = j / (W/2);
      if (s < 4) begin
        chk("crd", int'(crd), 1);
        chk("cwr", int'(cwr), 0);
        chk("pool_raddr", int'(caddr_rd), (2*py + s/2)*W + 2*px + s%2);
      end else begin
        chk("crd", int'(crd), 0);
        chk("cwr", int'(cwr), 1);
        chk("pool_csel", int'(csel), 1);
        chk("pool_addr", int'(caddr_wr), j);
        chk("pool_data", int'(cdata_wr), exp_l1[j]);
      end
    end else begin
      chk("idle_cwr", int'(cwr), 0);
      chk("idle_crd", int'(crd), 0);
      chk("idle_iaddr", int'(iaddr), 0);
      chk("idle_waddr", int'(caddr_wr), 0);
      chk("idle_raddr", int'(caddr_rd), 0);
      chk("idle_wdata", int'(cdata_wr), 0);
    end
  endtask

  // Single compare process: one check per cycle while a job is tracked
  always @(negedge clk) begin
    if (active) begin
      check_output(cyc);
      cyc++;
      if (cyc > total_len + 1) active = 1'b0;
    end
  end

  task automatic apply_stimulus(input bit hold, input int abort_at);
    bit aborted = 1'b0;
    compute_model();
    total_len = CONV_LEN + (m_pool != 0 ? POOL_LEN : 0);
    @(negedge clk);
    ready   = 1'b1;
    dil     = 2'(m_d - 1);
    pool_en = (m_pool != 0);
    bias    = DW'(m_bias);
    for (int i = 0; i < 9; i++) kernel[i*DW +: DW] = DW'(m_k[i]);
    @(posedge clk);
    #1;
    cyc = 0;
    active = 1'b1;
    if (hold) begin
      dil     = 2'($urandom_range(0, 3));
      pool_en = ~pool_en;
      bias    = DW'($urandom);
      kernel  = {4{$urandom}};
    end else begin
      ready = 1'b0;
    end
    for (int n = 0; n < total_len + 20 && active; n++) begin
      @(posedge clk);
      #1;
      if (hold && cyc >= total_len - 3) ready = 1'b0;
      if (abort_at > 0 && cyc >= abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      active = 1'b0;
      ready  = 1'b0;
      reset  = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_cwr", int'(cwr), 0);
      chk("abort_crd", int'(crd), 0);
      chk("abort_done", int'(done), 0);
      repeat (2) begin
        @(posedge clk);
        #1;
        chk("abort_hold_cwr", int'(cwr), 0);
        chk("abort_hold_busy", int'(busy), 0);
      end
      @(negedge clk);
      reset = 1'b0;
    end else begin
      chk("timeout", int'(active), 0);
      active = 1'b0;
      ready  = 1'b0;
    end
  endtask

  task automatic set_uniform(input int pix, input int centre, input int others,
                             input int b, input int dd, input int pl);
    for (int i = 0; i < W*H; i++) img_v[i] = pix;
    for (int i = 0; i < 9; i++) m_k[i] = (i == 4) ? centre : others;
    m_bias = b;
    m_d    = dd;
    m_pool = pl;
  endtask

  task automatic set_random();
    for (int i = 0; i < W*H; i++) img_v[i] = int'($urandom_range(0, 511)) - 256;
    for (int i = 0; i < 9; i++) m_k[i] = int'($urandom_range(0, 63)) - 32;
    m_bias = int'($urandom_range(0, 127)) - 64;
    m_d    = int'($urandom_range(1, 4));
    m_pool = int'($urandom_range(0, 1));
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) begin
      img_v[i]  = 0;
      l0_mem[i] = 0;
    end
    for (int i = 0; i < W*H/4; i++) l1_mem[i] = 0;
    reset = 1'b1;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cwr", int'(cwr), 0);
    chk("rst_crd", int'(crd), 0);
    chk("rst_csel", int'(csel), 0);
    chk("rst_iaddr", int'(iaddr), 0);
    chk("rst_waddr", int'(caddr_wr), 0);
    chk("rst_raddr", int'(caddr_rd), 0);
    chk("rst_wdata", int'(cdata_wr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Flat image, ring kernel, negative bias, d=2
    set_uniform(16, 0, 16, -12, 2, 1);
    compute_model();
    chk("model_flat_l0", exp_l0[27], 116);
    chk("model_flat_l1", exp_l1[5], 128);
    apply_stimulus(1'b0, 0);
    chk("flat_l0", l0_mem[63], 116);
    chk("flat_l1", l1_mem[15], 128);

    // Ramp image through identity kernel
    set_uniform(0, 16, 0, 0, 1, 1);
    for (int i = 0; i < W*H; i++) img_v[i] = i*16;
    compute_model();
    chk("model_ramp_l1", exp_l1[5], 27*16);
    apply_stimulus(1'b0, 0);
    chk("ramp_l0", l0_mem[37], 37*16);
    chk("ramp_l1", l1_mem[5], 27*16);

    // Single corner pixel with d=4 and no pooling
    set_uniform(0, 16, 16, 0, 4, 0);
    img_v[0] = 160;
    compute_model();
    chk("model_corner", exp_l0[0], 640);
    apply_stimulus(1'b0, 0);
    chk("corner_00", l0_mem[0], 640);
    chk("corner_44", l0_mem[36], 160);
    chk("corner_55", l0_mem[45], 0);

    // ReLU, saturation and fractional round-up
    set_uniform(100, -16, 0, 0, 1, 0);
    apply_stimulus(1'b0, 0);
    chk("relu_l0", l0_mem[0], 0);
    set_uniform(4000, 32, 0, 0, 1, 1);
    apply_stimulus(1'b0, 0);
    chk("sat_l0", l0_mem[9], 4095);
    chk("sat_l1", l1_mem[3], 4080);
    set_uniform(17, 16, 0, 0, 1, 1);
    apply_stimulus(1'b0, 0);
    chk("frac_l0", l0_mem[0], 17);
    chk("frac_l1", l1_mem[0], 32);

    // Ready and config churning while busy
    set_random();
    m_pool = 1;
    apply_stimulus(1'b1, 0);

    // Abort mid-conv, then a full restart with the same job
    set_random();
    m_pool = 1;
    apply_stimulus(1'b0, 300);
    apply_stimulus(1'b0, 0);

    for (int n = 0; n < 5; n++) begin
      set_random();
      apply_stimulus(1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
